// File: rtl/spi_cmd_ctrl_if.sv
// Memory-side request/acknowledge bus between the SPI command controller
// and the FPGA register/memory fabric.
//   mem_req   : request, held until acknowledged
//   mem_we    : 1 = write, 0 = read; stable while mem_req
//   mem_addr  : access address; stable while mem_req
//   mem_wdata : write data; stable while mem_req
//   mem_rdata : read data, valid in the mem_ack cycle of a read
//   mem_ack   : completes the access when high together with mem_req
// Modports: master = controller side, slave = memory side.
interface spi_cmd_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command/transaction controller.
// Parses each SPI frame as [cmd][addr_hi][addr_lo][data...] and performs
// auto-incrementing single-byte reads/writes on the memory bus, returning
// read data (one byte of prefetch latency) through tx_byte.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   spi_active            : slave select active (already synchronised)
//   rx_valid, rx_byte     : one-cycle received-byte strobe and byte
//   tx_byte               : byte loaded by the SPI slave at the next boundary
//   mem                   : memory req/ack bus (master modport)
//   busy                  : access in flight or a read waiting to issue
//   err_overrun           : sticky overrun flag
module spi_cmd_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_active,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic [7:0]            tx_byte,
    spi_cmd_ctrl_if.master        mem,
    output logic                  busy,
    output logic                  err_overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        WR_DATA = 3'd3,
        RD_DATA = 3'd4,
        IGNORE  = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic              is_write_r, is_write_s;
    logic [15:0]       addr_r, addr_s;
    logic [7:0]        prefetch_r, prefetch_s;
    logic              prefetch_valid_r, prefetch_valid_s;
    logic              rd_pending_r, rd_pending_s;
    logic              rd_discard_r, rd_discard_s;   // in-flight read belongs to an ended frame
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]        mem_wdata_r, mem_wdata_s;
    logic [7:0]        tx_byte_r, tx_byte_s;
    logic              err_overrun_r;
    logic              err_set_s, err_clr_s;

    logic              accept_s;
    logic              ack_s;
    logic              rd_ack_s;
    logic              rd_use_s;
    logic              busy_s;
    logic [7:0]        status_s;

    assign accept_s = rx_valid & spi_active;
    assign ack_s    = mem_req_r & mem.mem_ack;
    assign rd_ack_s = ack_s & ~mem_we_r;
    // Read data only feeds the current frame if that frame issued the read.
    assign rd_use_s = rd_ack_s & ~rd_discard_r & spi_active & (state_r == RD_DATA);
    assign busy_s   = mem_req_r | rd_pending_r;
    assign status_s = {6'b000000, err_overrun_r, busy_s};

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign tx_byte       = tx_byte_r;
    assign busy          = busy_s;
    assign err_overrun   = err_overrun_r;

    // Next-state, memory-issue and transmit-byte logic.
    always_comb begin
        state_s          = state_r;
        is_write_s       = is_write_r;
        addr_s           = addr_r;
        prefetch_s       = prefetch_r;
        prefetch_valid_s = prefetch_valid_r;
        rd_pending_s     = rd_pending_r;
        rd_discard_s     = rd_discard_r;
        mem_req_s        = mem_req_r;
        mem_we_s         = mem_we_r;
        mem_addr_s       = mem_addr_r;
        mem_wdata_s      = mem_wdata_r;
        tx_byte_s        = tx_byte_r;
        err_set_s        = 1'b0;
        err_clr_s        = 1'b0;

        if (ack_s) begin
            mem_req_s = 1'b0;
        end else begin
            mem_req_s = mem_req_r;
        end

        if (rd_ack_s) begin
            rd_discard_s = 1'b0;
        end else begin
            rd_discard_s = rd_discard_r;
        end

        if (!spi_active) begin
            // Frame end: drop frame context; an in-flight access runs to completion.
            state_s          = IDLE;
            prefetch_valid_s = 1'b0;
            rd_pending_s     = 1'b0;
            tx_byte_s        = status_s;
            if (mem_req_r && !mem_we_r && !ack_s) begin
                rd_discard_s = 1'b1;
            end else begin
                rd_discard_s = 1'b0;
            end
        end else begin
            if (rd_pending_r && !mem_req_r) begin
                mem_req_s    = 1'b1;
                mem_we_s     = 1'b0;
                mem_addr_s   = addr_r[ADDR_W-1:0];
                rd_pending_s = 1'b0;
            end else begin
                rd_pending_s = rd_pending_r;
            end

            case (state_r)
                IDLE: begin
                    tx_byte_s = status_s;
                    if (accept_s) begin
                        case (rx_byte)
                            8'h01: begin
                                is_write_s = 1'b1;
                                state_s    = ADDR_HI;
                            end
                            8'h02: begin
                                is_write_s = 1'b0;
                                state_s    = ADDR_HI;
                            end
                            8'h03: begin
                                err_clr_s = 1'b1;
                                state_s   = IGNORE;
                            end
                            default: begin
                                state_s = IGNORE;
                            end
                        endcase
                    end else begin
                        state_s = IDLE;
                    end
                end
                ADDR_HI: begin
                    if (accept_s) begin
                        addr_s[15:8] = rx_byte;
                        state_s      = ADDR_LO;
                    end else begin
                        state_s = ADDR_HI;
                    end
                end
                ADDR_LO: begin
                    if (accept_s) begin
                        addr_s[7:0] = rx_byte;
                        if (is_write_r) begin
                            state_s = WR_DATA;
                        end else begin
                            tx_byte_s    = 8'hFF;
                            rd_pending_s = 1'b1;
                            state_s      = RD_DATA;
                        end
                    end else begin
                        state_s = ADDR_LO;
                    end
                end
                WR_DATA: begin
                    if (accept_s) begin
                        if (!mem_req_r) begin
                            mem_req_s   = 1'b1;
                            mem_we_s    = 1'b1;
                            mem_wdata_s = rx_byte;
                            mem_addr_s  = addr_r[ADDR_W-1:0];
                            addr_s      = addr_r + 16'd1;
                        end else begin
                            err_set_s = 1'b1;
                        end
                    end else begin
                        state_s = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (accept_s && rd_use_s) begin
                        // Data arriving with the byte strobe goes straight out.
                        tx_byte_s        = mem.mem_rdata;
                        prefetch_valid_s = 1'b0;
                        rd_pending_s     = 1'b1;
                        addr_s           = addr_r + 16'd1;
                    end else if (rd_use_s) begin
                        prefetch_s       = mem.mem_rdata;
                        prefetch_valid_s = 1'b1;
                        addr_s           = addr_r + 16'd1;
                    end else if (accept_s) begin
                        if (prefetch_valid_r) begin
                            tx_byte_s        = prefetch_r;
                            prefetch_valid_s = 1'b0;
                            rd_pending_s     = 1'b1;
                        end else begin
                            tx_byte_s = 8'h00;
                            err_set_s = 1'b1;
                        end
                    end else begin
                        state_s = RD_DATA;
                    end
                end
                IGNORE: begin
                    tx_byte_s = 8'h00;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            is_write_r       <= 1'b0;
            addr_r           <= 16'h0000;
            prefetch_r       <= 8'h00;
            prefetch_valid_r <= 1'b0;
            rd_pending_r     <= 1'b0;
            rd_discard_r     <= 1'b0;
            mem_req_r        <= 1'b0;
            mem_we_r         <= 1'b0;
            mem_addr_r       <= {ADDR_W{1'b0}};
            mem_wdata_r      <= 8'h00;
            tx_byte_r        <= 8'h00;
        end else begin
            state_r          <= state_s;
            is_write_r       <= is_write_s;
            addr_r           <= addr_s;
            prefetch_r       <= prefetch_s;
            prefetch_valid_r <= prefetch_valid_s;
            rd_pending_r     <= rd_pending_s;
            rd_discard_r     <= rd_discard_s;
            mem_req_r        <= mem_req_s;
            mem_we_r         <= mem_we_s;
            mem_addr_r       <= mem_addr_s;
            mem_wdata_r      <= mem_wdata_s;
            tx_byte_r        <= tx_byte_s;
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overrun_r <= 1'b0;
        end else if (err_set_s) begin
            err_overrun_r <= 1'b1;
        end else if (err_clr_s) begin
            err_overrun_r <= 1'b0;
        end else begin
            err_overrun_r <= err_overrun_r;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed testbench for spi_cmd_ctrl: drives SPI byte strobes, models a
// byte-wide memory with programmable ack latency, and checks tx_byte,
// status flags and the logged memory accesses against hand-computed values.
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       busy;
    logic       err_overrun;

    spi_cmd_ctrl_if #(.ADDR_W(16)) mem ();

    spi_cmd_ctrl #(.ADDR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_active  (spi_active),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_byte     (tx_byte),
        .mem         (mem.master),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int ack_delay = 0;
    int byte_gap  = 20;
    int wait_cnt;

    logic [7:0] mem_arr [0:65535];
    int rd_log[$];
    int wr_addr_log[$];
    int wr_data_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks ack_delay cycles after the request is seen.
    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = 8'(i) ^ 8'h3C;
        mem_arr[16'h0010] = 8'h5A;
        mem_arr[16'h0011] = 8'hC3;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 8'h00;
        wait_cnt      = 0;
        forever begin
            @(negedge clk);
            if (mem.mem_ack) begin
                mem.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (mem.mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem.mem_ack = 1'b1;
                    if (mem.mem_we) begin
                        mem_arr[mem.mem_addr] = mem.mem_wdata;
                        wr_addr_log.push_back(int'(mem.mem_addr));
                        wr_data_log.push_back(int'(mem.mem_wdata));
                    end else begin
                        mem.mem_rdata = mem_arr[mem.mem_addr];
                        rd_log.push_back(int'(mem.mem_addr));
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (byte_gap) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk);
        spi_active = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        spi_active = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_req_low(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!mem.mem_req) break;
            @(negedge clk);
        end
        chk(tag, 32'(mem.mem_req), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        spi_active = 1'b0;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem.mem_req), 32'd0);
        chk("rst_addr", 32'(mem.mem_addr), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_tx", 32'(tx_byte), 32'h00);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(err_overrun), 32'd0);

        // WRITE 01 12 34 AA BB, ack one cycle after request
        ack_delay = 0;
        frame_start();
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAA); send_byte(8'hBB);
        frame_end();
        chk("wr_cnt", 32'(wr_addr_log.size()), 32'd2);
        chk("wr0_addr", 32'(wr_addr_log[0]), 32'h1234);
        chk("wr0_data", 32'(wr_data_log[0]), 32'hAA);
        chk("wr1_addr", 32'(wr_addr_log[1]), 32'h1235);
        chk("wr1_data", 32'(wr_data_log[1]), 32'hBB);
        chk("wr_err", 32'(err_overrun), 32'd0);

        // READ 02 00 10 + three data bytes
        rd_log.delete();
        frame_start();
        chk("rd_status", 32'(tx_byte), 32'h00);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
        chk("rd_pad", 32'(tx_byte), 32'hFF);
        send_byte(8'h00);
        chk("rd_d0", 32'(tx_byte), 32'h5A);
        send_byte(8'h00);
        chk("rd_d1", 32'(tx_byte), 32'hC3);
        send_byte(8'h00);
        chk("rd_d2", 32'(tx_byte), 32'h2E);
        frame_end();
        wait_req_low("rd_req_drop");
        chk("rd_log0", 32'(rd_log[0]), 32'h0010);
        chk("rd_log1", 32'(rd_log[1]), 32'h0011);
        chk("rd_log2", 32'(rd_log[2]), 32'h0012);
        chk("rd_err", 32'(err_overrun), 32'd0);

        // Overrun: slow ack, second data byte while write still in flight
        wr_addr_log.delete();
        wr_data_log.delete();
        ack_delay = 40;
        frame_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
        byte_gap = 20;
        send_byte(8'h11);
        byte_gap = 2;
        send_byte(8'h22);
        chk("ovr_err", 32'(err_overrun), 32'd1);
        frame_end();
        chk("ovr_status_busy", 32'(tx_byte), 32'h03);
        wait_req_low("ovr_req_drop");
        repeat (2) @(negedge clk);
        chk("ovr_status", 32'(tx_byte), 32'h02);
        chk("ovr_wr_cnt", 32'(wr_addr_log.size()), 32'd1);
        chk("ovr_wr_addr", 32'(wr_addr_log[0]), 32'h0020);
        chk("ovr_wr_data", 32'(wr_data_log[0]), 32'h11);
        ack_delay = 0;
        byte_gap  = 20;
        frame_start();
        send_byte(8'h03);
        chk("clr_ignore_tx", 32'(tx_byte), 32'h00);
        frame_end();
        chk("clr_err", 32'(err_overrun), 32'd0);
        chk("clr_status", 32'(tx_byte), 32'h00);

        // Address wrap: READ at 0xFFFF
        rd_log.delete();
        frame_start();
        send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h00);
        chk("wrap_d0", 32'(tx_byte), 32'hC3);
        send_byte(8'h00);
        chk("wrap_d1", 32'(tx_byte), 32'h3C);
        send_byte(8'h00);
        chk("wrap_d2", 32'(tx_byte), 32'h3D);
        frame_end();
        wait_req_low("wrap_req_drop");
        chk("wrap_log0", 32'(rd_log[0]), 32'hFFFF);
        chk("wrap_log1", 32'(rd_log[1]), 32'h0000);
        chk("wrap_log2", 32'(rd_log[2]), 32'h0001);

        // Frame drop with read still in flight
        ack_delay = 10;
        frame_start();
        send_byte(8'h02); send_byte(8'h00);
        byte_gap = 2;
        send_byte(8'h40);
        @(negedge clk);
        spi_active = 1'b0;
        repeat (2) @(negedge clk);
        chk("drop_req", 32'(mem.mem_req), 32'd1);
        chk("drop_busy", 32'(busy), 32'd1);
        chk("drop_status", 32'(tx_byte), 32'h01);
        chk("drop_state", 32'(dut.state_r), 32'd0);
        wait_req_low("drop_req_drop");
        repeat (2) @(negedge clk);
        chk("drop_idle_busy", 32'(busy), 32'd0);
        chk("drop_idle_tx", 32'(tx_byte), 32'h00);

        // Reset in the middle of a WRITE access
        ack_delay = 30;
        byte_gap  = 20;
        frame_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h50);
        byte_gap = 2;
        send_byte(8'h77);
        chk("rstw_req_hi", 32'(mem.mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_req", 32'(mem.mem_req), 32'd0);
        chk("rstw_state", 32'(dut.state_r), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        rst        = 1'b0;
        spi_active = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
